// File: rtl/irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source sync, level/edge capture, masking,
// a registered irq line and a lowest-index-first vector register.
module irq_aggregator #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] EDGE_RESET  = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    typedef enum logic [2:0] {
        REG_PENDING  = 3'd0,
        REG_MASK     = 3'd1,
        REG_EDGE_SEL = 3'd2,
        REG_VECTOR   = 3'd3,
        REG_FORCE    = 3'd4,
        REG_RAW      = 3'd5
    } reg_addr_e;

    logic [NUM_IRQ-1:0] w_s;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_edge;
    logic [15:0]        r_readdata;
    logic               r_irq_out;

    logic               w_wr;
    logic [NUM_IRQ-1:0] w_wdata;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_mode_chg;
    logic [NUM_IRQ-1:0] w_pending_next;
    logic [NUM_IRQ-1:0] w_active;
    logic               w_valid;
    logic [3:0]         w_idx;
    logic               w_found;
    logic [15:0]        w_rdmux;
    logic               w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_wdata  = writedata[NUM_IRQ-1:0];
    assign w_unused = ^writedata;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = irq_in;
        end else begin : g_sync
            logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
                end else begin
                    r_sync[0] <= irq_in;
                    for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Edge bits: set wins over clear, else hold. Level bits follow the input.
    // A mode change on EDGE_SEL write zeroes the affected bits for one cycle.
    always_comb begin
        w_set          = (w_s & ~r_prev) | ((w_wr && address == REG_FORCE) ? w_wdata : '0);
        w_clr          = (w_wr && address == REG_PENDING) ? w_wdata : '0;
        w_mode_chg     = (w_wr && address == REG_EDGE_SEL) ? (w_wdata ^ r_edge) : '0;
        w_pending_next = ((r_edge & (w_set | (r_pending & ~w_clr))) | (~r_edge & w_s)) & ~w_mode_chg;
    end

    assign w_active = r_pending & r_mask;
    assign w_valid  = |w_active;

    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (w_active[i] && !w_found) begin
                w_idx   = 4'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdmux = '0;
        case (address)
            REG_PENDING:  w_rdmux = 16'(r_pending);
            REG_MASK:     w_rdmux = 16'(r_mask);
            REG_EDGE_SEL: w_rdmux = 16'(r_edge);
            REG_VECTOR:   w_rdmux = {w_valid, 11'b0, w_idx};
            REG_RAW:      w_rdmux = 16'(w_s);
            default:      w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_edge     <= EDGE_RESET[NUM_IRQ-1:0];
            r_readdata <= '0;
            r_irq_out  <= 1'b0;
        end else begin
            r_prev     <= w_s;
            r_pending  <= w_pending_next;
            r_readdata <= w_rdmux;
            r_irq_out  <= w_valid;
            if (w_wr && address == REG_MASK)     r_mask <= w_wdata;
            if (w_wr && address == REG_EDGE_SEL) r_edge <= w_wdata;
        end
    end

    assign readdata = r_readdata;
    assign irq_out  = r_irq_out;

endmodule
